// File: rtl/fsm_step_sequencer.sv
// fsm_step_sequencer: drives a two-flip-flop datapath (state bits A, B) with a
// programmed serial x_in pattern for a set number of steps, then captures the
// final {A,B} state and pulses done.
// Optional feature: define VISIT_CNT_EN to build per-state visit counters;
// when undefined, visit_cnt is tied to zero and no counter logic exists.
module fsm_step_sequencer #(
    parameter int unsigned PAT_W = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic               clk,
    input  logic               res,
    input  logic               start,
    input  logic               abort,
    input  logic [PAT_W-1:0]   pattern,
    input  logic [CNT_W-1:0]   steps,
    input  logic               state_a,
    input  logic               state_b,
    output logic               x_in,
    output logic               dp_res,
    output logic               busy,
    output logic               done,
    output logic [1:0]         final_state,
    output logic [4*CNT_W-1:0] visit_cnt
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CLR  = 3'd1;
    localparam logic [2:0] RUN  = 3'd2;
    localparam logic [2:0] CAP  = 3'd3;
    localparam logic [2:0] DONE = 3'd4;

    logic [2:0]       state_q, state_d;
    logic [PAT_W-1:0] shift_q;
    logic [CNT_W-1:0] remain_q;
    logic             dp_res_q;
    logic [1:0]       final_q;
    logic             in_busy;

    assign in_busy = (state_q == CLR) || (state_q == RUN) || (state_q == CAP);

    // Next-state decode; abort overrides every transition while busy.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = CLR;
            CLR:     state_d = (remain_q != '0) ? RUN : CAP;
            RUN:     if (remain_q == CNT_W'(1)) state_d = CAP;
            CAP:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && in_busy) begin
            state_d = IDLE;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Pattern shift register and remaining-step count: load on accept, rotate in RUN.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            shift_q  <= '0;
            remain_q <= '0;
        end else if (state_q == IDLE && start) begin
            shift_q  <= pattern;
            remain_q <= steps;
        end else if (state_q == RUN) begin
            shift_q  <= {shift_q[0], shift_q[PAT_W-1:1]};
            remain_q <= remain_q - CNT_W'(1);
        end
    end

    // Datapath reset is registered so it stays low only for the CLR cycle.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            dp_res_q <= 1'b0;
        end else begin
            dp_res_q <= (state_d != CLR);
        end
    end

    // Capture {A,B} on the edge leaving CAP, unless the run is being aborted.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            final_q <= 2'b00;
        end else if (state_q == CAP && !abort) begin
            final_q <= {state_a, state_b};
        end
    end

    // Outputs decoded from state/shift registers only.
    always_comb begin
        x_in        = (state_q == RUN) & shift_q[0];
        dp_res      = dp_res_q;
        busy        = in_busy;
        done        = (state_q == DONE);
        final_state = final_q;
    end

`ifdef VISIT_CNT_EN
    logic [CNT_W-1:0] visit_q [4];
    logic [1:0]       visit_idx;

    assign visit_idx = {state_a, state_b};

    // Saturating per-state visit counters: clear in CLR, count in RUN, hold otherwise.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int k = 0; k < 4; k++) begin
                visit_q[k] <= '0;
            end
        end else if (state_q == CLR) begin
            for (int k = 0; k < 4; k++) begin
                visit_q[k] <= '0;
            end
        end else if (state_q == RUN) begin
            if (visit_q[visit_idx] != '1) begin
                visit_q[visit_idx] <= visit_q[visit_idx] + CNT_W'(1);
            end
        end
    end

    // Pack counters so slice k holds the count for state {A,B}=k.
    always_comb begin
        visit_cnt = '0;
        for (int k = 0; k < 4; k++) begin
            visit_cnt[k*CNT_W +: CNT_W] = visit_q[k];
        end
    end
`else
    assign visit_cnt = '0;
`endif

endmodule

// File: tb/tb_fsm_step_sequencer.sv
// Directed bench for fsm_step_sequencer with a behavioural two-flip-flop
// datapath: x=0 steps 00->10->11->01->00, x=1 holds.
module tb_fsm_step_sequencer;

    logic        clk;
    logic        res;
    logic        start;
    logic        abort;
    logic [7:0]  pattern;
    logic [3:0]  steps;
    logic        x_in;
    logic        dp_res;
    logic        busy;
    logic        done;
    logic [1:0]  final_state;
    logic [15:0] visit_cnt;
    logic [1:0]  ab;

    int checks;
    int failures;

    fsm_step_sequencer #(
        .PAT_W(8),
        .CNT_W(4)
    ) dut (
        .clk        (clk),
        .res        (res),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .steps      (steps),
        .state_a    (ab[1]),
        .state_b    (ab[0]),
        .x_in       (x_in),
        .dp_res     (dp_res),
        .busy       (busy),
        .done       (done),
        .final_state(final_state),
        .visit_cnt  (visit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [1:0] dp_next(input logic [1:0] s, input logic x);
        if (x) return s;
        case (s)
            2'b00:   return 2'b10;
            2'b10:   return 2'b11;
            2'b11:   return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Bench datapath
    always_ff @(posedge clk or negedge dp_res) begin
        if (!dp_res) ab <= 2'b00;
        else         ab <= dp_next(ab, x_in);
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One full run; poke raises start during the first post-CLR cycle (must be ignored).
    task automatic run_check(input string tag, input logic [7:0] pat, input logic [3:0] stp,
                             input logic [1:0] exp_final, input bit poke);
        logic [1:0]  m;
        int          v[4];
        logic        exp_x;
        logic [15:0] exp_visit;
        m = 2'b00;
        for (int k = 0; k < 4; k++) v[k] = 0;
        @(negedge clk);
        start = 1'b1; pattern = pat; steps = stp;
        @(negedge clk);
        start = 1'b0;
        check_eq({tag, ":clr_dp_res"}, 32'(dp_res), 32'd0);
        check_eq({tag, ":clr_busy"}, 32'(busy), 32'd1);
        for (int c = 2; c <= int'(stp) + 2; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c <= int'(stp) + 1) begin
                exp_x = pat[(c - 2) % 8];
                v[m] = v[m] + 1;
                m = dp_next(m, exp_x);
            end else begin
                exp_x = 1'b0;
            end
            check_eq({tag, ":x_in"}, 32'(x_in), 32'(exp_x));
            check_eq({tag, ":busy"}, 32'(busy), 32'd1);
            check_eq({tag, ":dp_res"}, 32'(dp_res), 32'd1);
            check_eq({tag, ":early_done"}, 32'(done), 32'd0);
            if (poke && c == 2) start = 1'b1;
        end
        @(negedge clk);
        start = 1'b0;
`ifdef VISIT_CNT_EN
        exp_visit = {4'(v[3]), 4'(v[2]), 4'(v[1]), 4'(v[0])};
`else
        exp_visit = 16'h0000;
`endif
        check_eq({tag, ":done"}, 32'(done), 32'd1);
        check_eq({tag, ":done_busy"}, 32'(busy), 32'd0);
        check_eq({tag, ":final"}, 32'(final_state), 32'(exp_final));
        check_eq({tag, ":visit"}, 32'(visit_cnt), 32'(exp_visit));
        @(negedge clk);
        check_eq({tag, ":idle_done"}, 32'(done), 32'd0);
        check_eq({tag, ":idle_busy"}, 32'(busy), 32'd0);
        @(negedge clk);
        check_eq({tag, ":no_requeue"}, 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        failures = 0;
        res = 1'b0; start = 1'b0; abort = 1'b0; pattern = 8'h00; steps = 4'd0;
        #1;
        check_eq("rst_x_in", 32'(x_in), 32'd0);
        check_eq("rst_dp_res", 32'(dp_res), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_final", 32'(final_state), 32'd0);
        check_eq("rst_visit", 32'(visit_cnt), 32'd0);
        @(negedge clk);
        @(negedge clk);
        res = 1'b1;
        @(negedge clk);
        check_eq("post_rst_dp_res", 32'(dp_res), 32'd1);
        check_eq("post_rst_busy", 32'(busy), 32'd0);

        run_check("basic", 8'h00, 4'd3, 2'b01, 1'b1);
        run_check("hold", 8'hFF, 4'd5, 2'b00, 1'b0);
        run_check("mixed", 8'b0000_0010, 4'd2, 2'b10, 1'b0);

        // Abort in the second RUN cycle
        @(negedge clk);
        start = 1'b1; pattern = 8'h00; steps = 4'd5;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(done), 32'd0);
        check_eq("abort_final", 32'(final_state), 32'd2);
        check_eq("abort_x_in", 32'(x_in), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check_eq("abort_no_done", 32'(done), 32'd0);
        end

        run_check("wrap", 8'b0000_0010, 4'd10, 2'b00, 1'b0);
        run_check("zero", 8'hA5, 4'd0, 2'b00, 1'b0);
        run_check("visit4", 8'h00, 4'd4, 2'b00, 1'b0);
        run_check("visit15", 8'h00, 4'd15, 2'b01, 1'b0);

        // Reset asserted mid-run
        @(negedge clk);
        start = 1'b1; pattern = 8'h00; steps = 4'd8;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        res = 1'b0;
        #1;
        check_eq("midrst_busy", 32'(busy), 32'd0);
        check_eq("midrst_final", 32'(final_state), 32'd0);
        check_eq("midrst_visit", 32'(visit_cnt), 32'd0);
        check_eq("midrst_dp_res", 32'(dp_res), 32'd0);
        check_eq("midrst_x_in", 32'(x_in), 32'd0);
        @(negedge clk);
        res = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            check_eq("midrst_no_done", 32'(done), 32'd0);
        end
        check_eq("midrst_dp_res_up", 32'(dp_res), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
